// File: rtl/sensor_pkg.sv
// Shared definitions for the TDC sensor trace path: FSM state codes and
// the marker written in place of a sample while the AES result is valid.
package sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } trace_state_e;

    localparam int unsigned MARK_DONE_DEF = 255;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module trace_ram #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_capture_buf.sv
// Pre/post-trigger trace capture of TDC sensor samples around an AES start,
// frozen for readout with the oldest kept sample at logical index 0.
module trace_capture_buf
    import sensor_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AW        = 10,
    parameter int unsigned DW        = 8,
    parameter int unsigned PRE       = 64,
    parameter int unsigned MARK_DONE = MARK_DONE_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] sample_i,
    input  logic          sample_vld_i,
    input  logic          arm_i,
    input  logic          trig_i,
    input  logic          done_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic [1:0]    state_o,
    output logic          ready_o,
    output logic [AW:0]   pre_cnt_o
);

    localparam logic [AW:0] PRE_L  = (AW+1)'(PRE);
    localparam logic [AW:0] POST_L = (AW+1)'(DEPTH - PRE);

    logic          rst_meta_q, rst_sync_q;
    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] trig_ptr_q, trig_ptr_d;
    logic [AW:0]   pre_cnt_q, pre_cnt_d;
    logic [AW:0]   post_cnt_q, post_cnt_d;
    logic          rd_ok_q, rd_ok_d;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [AW-1:0] start_addr, ram_raddr;
    logic [AW:0]   rd_limit;

    // Assertion is immediate; release reaches the logic two edges later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
            rd_ok_q    <= rd_ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        trig_ptr_d = trig_ptr_q;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        ram_we     = 1'b0;
        ram_wdata  = done_i ? DW'(MARK_DONE) : sample_i;

        case (state_q)
            ST_IDLE, ST_FROZEN: begin
                if (arm_i) begin
                    state_d   = ST_ARMED;
                    wr_ptr_d  = '0;
                    pre_cnt_d = '0;
                end
            end
            ST_ARMED: begin
                if (sample_vld_i) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    // The trigger sample counts as the first post sample, not a pre sample.
                    if (trig_i) begin
                        trig_ptr_d = wr_ptr_q;
                        post_cnt_d = (AW+1)'(1);
                        state_d    = (POST_L == (AW+1)'(1)) ? ST_FROZEN : ST_CAPTURE;
                    end else if (pre_cnt_q < PRE_L) begin
                        pre_cnt_d = pre_cnt_q + (AW+1)'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                if (sample_vld_i) begin
                    ram_we     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + AW'(1);
                    post_cnt_d = post_cnt_q + (AW+1)'(1);
                    if (post_cnt_d == POST_L) begin
                        state_d = ST_FROZEN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Logical-to-physical mapping; the limit never exceeds DEPTH since pre_cnt <= PRE.
    always_comb begin
        start_addr = trig_ptr_q - pre_cnt_q[AW-1:0];
        ram_raddr  = start_addr + rd_addr_i;
        rd_limit   = pre_cnt_q + POST_L;
        rd_ok_d    = (state_q == ST_FROZEN) && ({1'b0, rd_addr_i} < rd_limit);
    end

    trace_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_trace_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign rd_data_o = rd_ok_q ? ram_rdata : '0;
    assign state_o   = state_q;
    assign ready_o   = (state_q == ST_FROZEN);
    assign pre_cnt_o = pre_cnt_q;

endmodule

// File: tb/tb_trace_capture_buf.sv
// Bench for trace_capture_buf: directed captures with constant readout tables
// plus randomized captures checked against a queue-based trace model.
module tb_trace_capture_buf;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int PRE   = 64;
    localparam int POST  = DEPTH - PRE;
    localparam int MARK  = 255;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [DW-1:0] sample_i = '0;
    logic          sample_vld_i = 1'b0;
    logic          arm_i = 1'b0;
    logic          trig_i = 1'b0;
    logic          done_i = 1'b0;
    logic [AW-1:0] rd_addr_i = '0;
    logic [DW-1:0] rd_data_o;
    logic [1:0]    state_o;
    logic          ready_o;
    logic [AW:0]   pre_cnt_o;

    trace_capture_buf #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .DW        (DW),
        .PRE       (PRE),
        .MARK_DONE (MARK)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_i     (sample_i),
        .sample_vld_i (sample_vld_i),
        .arm_i        (arm_i),
        .trig_i       (trig_i),
        .done_i       (done_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .state_o      (state_o),
        .ready_o      (ready_o),
        .pre_cnt_o    (pre_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: every sample written before the trigger, and every sample from the trigger on.
    int         m_st = 0;
    logic [7:0] pre_q[$];
    logic [7:0] post_q[$];

    typedef struct {
        int scen;
        int k;
        int exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_pre();
        return (pre_q.size() < PRE) ? pre_q.size() : PRE;
    endfunction

    function automatic int m_read(input int k);
        int p;
        p = m_pre();
        if (m_st != 3) return 0;
        if (k < p) return int'(pre_q[pre_q.size() - p + k]);
        if (k < p + post_q.size()) return int'(post_q[k - p]);
        return 0;
    endfunction

    function automatic void m_step();
        logic [7:0] w;
        w = done_i ? 8'(MARK) : sample_i;
        case (m_st)
            0, 3: if (arm_i) begin
                m_st = 1;
                pre_q.delete();
                post_q.delete();
            end
            1: if (sample_vld_i) begin
                if (trig_i) begin
                    post_q.push_back(w);
                    m_st = (post_q.size() == POST) ? 3 : 2;
                end else begin
                    pre_q.push_back(w);
                end
            end
            2: if (sample_vld_i) begin
                post_q.push_back(w);
                if (post_q.size() == POST) m_st = 3;
            end
            default: ;
        endcase
    endfunction

    task automatic tick();
        int exp_rd;
        exp_rd = m_read(int'(rd_addr_i));
        m_step();
        @(posedge clk);
        #1;
        chk("state_o", int'(state_o), m_st);
        chk("ready_o", int'(ready_o), (m_st == 3) ? 1 : 0);
        chk("pre_cnt_o", int'(pre_cnt_o), m_pre());
        chk("rd_data_o", int'(rd_data_o), exp_rd);
    endtask

    task automatic cyc(input bit v, input int s, input bit t, input bit a, input bit d);
        sample_vld_i = v;
        sample_i     = DW'(s);
        trig_i       = t;
        arm_i        = a;
        done_i       = d;
        tick();
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        m_st = 0;
        pre_q.delete();
        post_q.delete();
        #1;
        chk("rst_state_o", int'(state_o), 0);
        chk("rst_ready_o", int'(ready_o), 0);
        chk("rst_rd_data_o", int'(rd_data_o), 0);
        chk("rst_pre_cnt_o", int'(pre_cnt_o), 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        rstn = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic readout();
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr_i = AW'(k);
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    task automatic check_table(input int sc);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].scen == sc) begin
                rd_addr_i = AW'(tbl[i].k);
                cyc(0, 0, 0, 0, 0);
                chk($sformatf("tbl_s%0d_k%0d", sc, tbl[i].k), int'(rd_data_o), tbl[i].exp);
            end
        end
    endtask

    // Arm, then samples n = 0.. with value n mod 200, trigger on sample npre.
    task automatic run_directed(input int npre, input int done_lo, input int done_hi);
        cyc(0, 0, 0, 1, 0);
        for (int n = 0; n < npre + POST; n++) begin
            cyc(1, n % 200, n == npre, 0, (n >= done_lo) && (n <= done_hi));
        end
        chk("frozen_after_post", int'(state_o), 3);
    endtask

    task automatic run_random(input int npre, input bit first_full_rate);
        cyc(0, 0, 0, 1, 0);
        while (pre_q.size() < npre) begin
            cyc(first_full_rate ? 1'b1 : 1'($urandom % 2), $urandom_range(0, 255), 0, 0,
                ($urandom % 16) == 0);
        end
        cyc(1, $urandom_range(1, 254), 1, 0, 0);
        for (int b = 0; b < 5000 && m_st == 2; b++) begin
            cyc(1'($urandom % 2), $urandom_range(0, 255), ($urandom % 8) == 0,
                ($urandom % 16) == 0, ($urandom % 32) == 0);
        end
        chk("random_frozen", int'(state_o), 3);
    endtask

    initial begin
        tbl.push_back('{1, 0, 36});
        tbl.push_back('{1, 1, 37});
        tbl.push_back('{1, 63, 99});
        tbl.push_back('{1, 64, 100});
        tbl.push_back('{1, 164, 0});
        tbl.push_back('{1, 1023, 59});
        tbl.push_back('{2, 0, 0});
        tbl.push_back('{2, 10, 10});
        tbl.push_back('{2, 969, 169});
        tbl.push_back('{2, 970, 0});
        tbl.push_back('{2, 1023, 0});
        tbl.push_back('{3, 562, 198});
        tbl.push_back('{3, 563, 255});
        tbl.push_back('{3, 564, 255});
        tbl.push_back('{3, 565, 255});
        tbl.push_back('{3, 566, 2});

        #2;
        reset_dut();
        repeat (3) cyc(1, 7, 1, 0, 0);

        run_directed(100, -1, -1);
        chk("s1_pre_cnt", int'(pre_cnt_o), 64);
        check_table(1);
        readout();

        run_directed(10, -1, -1);
        chk("s2_pre_cnt", int'(pre_cnt_o), 10);
        check_table(2);
        readout();

        run_directed(100, 599, 601);
        check_table(3);
        readout();

        run_random($urandom_range(0, 150), 1'b0);
        readout();

        run_random(2000, 1'b1);
        readout();
        rd_addr_i = AW'(PRE);
        cyc(0, 0, 0, 0, 0);
        chk("s5_trigger_sample_nonzero", (rd_data_o != '0) ? 1 : 0, 1);
        reset_dut();

        cyc(0, 0, 0, 1, 0);
        for (int n = 0; n < 20; n++) cyc(1, $urandom_range(0, 255), 0, 0, 0);
        cyc(1, 77, 1, 0, 0);
        while (post_q.size() < 300) cyc(1, $urandom_range(0, 255), 0, 0, 0);
        chk("s6_capturing", int'(state_o), 2);
        reset_dut();
        for (int n = 0; n < 5; n++) begin
            rd_addr_i = AW'(n);
            cyc(1, $urandom_range(0, 255), 1, 0, 0);
        end
        chk("s6_trig_ignored", int'(state_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got no end of test within 100000 cycles, expected end of test");
        $fatal(1);
    end

endmodule

// File: doc/trace_capture_buf.md
TRACE_CAPTURE_BUF -- requirements
Module: trace_capture_buf

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 1024, total samples held per trace (power of two).
- AW, 10, address width, log2(DEPTH).
- DW, 8, sample width.
- PRE, 64, pre-trigger samples kept (0 <= PRE < DEPTH).
- MARK_DONE, 255, code substituted for the sample when done_i is high.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- sample_i  in  DW  decoded TDC sensor value.
- sample_vld_i  in  1  sample_i valid this cycle; when low, no write and no counting.
- arm_i  in  1  pulse; starts or restarts a capture.
- trig_i  in  1  pulse; AES start (Drdy).
- done_i  in  1  AES result valid (Dvld).
- rd_addr_i  in  AW  logical readout index, 0 = oldest sample.
- rd_data_o  out  DW  sample at rd_addr_i.
- state_o  out  2  current FSM state code.
- ready_o  out  1  trace frozen and readable.
- pre_cnt_o  out  AW+1  pre-trigger samples actually stored.

Function
REQ-003 The FSM SHALL have four states: IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3.
REQ-004 IDLE: no writes. arm_i -> ARMED with wr_ptr=0 and pre_cnt=0.
REQ-005 ARMED: each valid sample SHALL be written at wr_ptr, then wr_ptr increments modulo DEPTH. pre_cnt increments and saturates at PRE.
REQ-006 ARMED with trig_i: the same-cycle valid sample SHALL be written as the trigger sample. trig_ptr is latched as wr_ptr of that sample. post_cnt is set to 1. Next state is CAPTURE.
REQ-007 CAPTURE: each valid sample SHALL be written and post_cnt incremented. At post_cnt = DEPTH-PRE, the FSM SHALL go to FROZEN.
REQ-008 A written value SHALL be MARK_DONE whenever done_i is high, otherwise sample_i. This applies in ARMED and CAPTURE.
REQ-009 trig_i outside ARMED SHALL be ignored. arm_i in ARMED or CAPTURE SHALL be ignored.
REQ-010 FROZEN: no writes. ready_o = 1. arm_i -> ARMED; contents are not cleared, but pre_cnt and wr_ptr reset to 0.
REQ-011 Logical start index SHALL be (trig_ptr - pre_cnt) mod DEPTH. Logical index k maps to physical address (start + k) mod DEPTH.
REQ-012 The trigger sample SHALL appear at logical index pre_cnt.
REQ-013 rd_data_o SHALL be registered, with one-cycle latency from rd_addr_i.
REQ-014 rd_data_o SHALL be 0 when the FSM is not FROZEN in the cycle the address is sampled.
REQ-015 Logical indices at or above pre_cnt + (DEPTH-PRE) SHALL read 0.
REQ-016 Memory SHALL be a single-clock simple dual-port array: one write port, one registered read port, inferable as block RAM.
REQ-017 Pointer arithmetic SHALL be AW bits wide with natural wrap-around. pre_cnt_o SHALL never exceed PRE.

Reset
REQ-018 rstn low SHALL force the following regardless of clk:
- state IDLE;
- wr_ptr, trig_ptr, pre_cnt, post_cnt = 0;
- rd_data_o = 0, ready_o = 0, state_o = 0.
REQ-019 Memory contents SHALL NOT be reset.
REQ-020 Reset mid-capture SHALL abandon the trace. After release, a new arm_i is required.
REQ-021 rstn deassertion SHALL be synchronised to clk with a two-flop release synchroniser inside the block.

Structure
REQ-022 State encodings and the MARK_DONE default SHALL live in shared package sensor_pkg, reused by the trace readout FSM.
REQ-023 The memory SHALL be one sub-module, trace_ram (DW x DEPTH, write port plus registered read port). Control, pointers and address mapping stay in trace_capture_buf.

Verification
REQ-024 Bench scenarios (DEPTH=1024, PRE=64), stimulus -> required response:
- Short pre-trigger: arm; 100 valid samples value n mod 200; trig_i on sample 100; continuous valid -> FROZEN after 960 post samples. Logical 0 reads 36 (sample 36). Logical 64 reads 100. pre_cnt_o = 64.
- Early trigger: arm; 10 samples; trig -> pre_cnt_o = 10. Trigger sample at logical 10. Logical 970..1023 read 0.
- Done marking: done_i high for 3 cycles at post sample 500 -> logical PRE+499..PRE+501 read 255. Neighbouring samples are unchanged.
- Stall handling: sample_vld_i toggling 50% during CAPTURE -> exactly 960 post samples stored, none duplicated. The FROZEN transition occurs after the 960th valid.
- Reset mid-capture: rstn low at post sample 300 -> state_o = 0, ready_o = 0, rd_data_o = 0 immediately. trig_i alone then has no effect.
- Re-arm and pointer wrap: FROZEN; arm; 2000 samples; trigger -> logical addresses wrap correctly across physical 1023 -> 0. trig_i or arm_i during CAPTURE is ignored.
